svmod_ctrl: RTL and testbench
=============================

# svmod_ctrl

Parametrised supervisor-mode stop controller for OCD/ICE emulation. It merges break requests from the on-chip debugger and the ICE break unit, and sequences a stop/release of N peripheral groups through a per-group acknowledge handshake. Peripherals restart a programmable number of cycles before the CPU. It also holds the emulation standby-release request until the clock/standby controller accepts it. The block sits between chip.ocd / ice.break and the chip peripherals, CPU and CSC.

## Interface
Parameters:
- NPERI, 4, number of peripheral stop groups (1..16)
- CW, 4, width of release-delay count

Ports:
- CLK  in  1  system clock
- RESB  in  1  asynchronous active-low reset
- SVSTOPICE  in  1  OCD stop request (chip.ocd)
- SVMODI  in  1  ICE stop request (ice.break)
- SVPERIICE  in  NPERI  OCD per-group peripheral stop, pass-through
- SVMODIPERI  in  NPERI  ICE per-group peripheral stop, pass-through
- SVMODOPBRK  in  1  open-break stop request (ice.break)
- PERIMSK  in  NPERI  1 = group is stopped by a break sequence (quasi-static)
- PERIACK  in  NPERI  group has reached its stop point (level)
- RELCNT  in  CW  release delay, in cycles, from peripheral release to CPU release (quasi-static)
- MONMD  in  1  OCD monitor mode (chip.cpu)
- SVMOD  in  1  ICE supervisor mode (chip.cpu)
- STBRELE  in  1  standby release (chip.int)
- STBRELESV  in  1  ICE standby release (ice.break)
- STBACK  in  1  CSC accepted standby release
- SVSTOP  out  1  CPU stop (to chip)
- SVPERI  out  NPERI  peripheral group stop (to chip)
- SVPERIOPBRK  out  NPERI  open-break group stop (to chip)
- STOPACK  out  1  all masked groups are stopped
- MONSVMOD  out  1  MONMD | SVMOD (to chip.ocd)
- STBRELEICE  out  1  held standby release (to chip.csc)

## Operation
- BRKREQ = SVSTOPICE | SVMODI. ACKALL = &(PERIACK | ~PERIMSK).
- FSM states: RUN, STOP, STOPPED, RELEASE. Reset state is RUN.
- RUN: if BRKREQ is 1, go to STOP and set SVSTOP<=1.
- STOP: wait for ACKALL. When ACKALL is 1, go to STOPPED and set STOPACK<=1, whatever BRKREQ is. A stop handshake is never aborted.
- STOPPED: if BRKREQ is 0, go to RELEASE, set STOPACK<=0 and load cnt<=RELCNT.
- RELEASE:
  - If BRKREQ is 1, return to STOP. SVSTOP stays 1 and the group stop is reasserted.
  - Otherwise, if cnt==0, go to RUN and set SVSTOP<=0.
  - Otherwise, cnt<=cnt-1.
- Group stop: grpstop = PERIMSK when state is STOP or STOPPED, else 0.
- SVPERI[i]<=grpstop[i] | SVPERIICE[i] | SVMODIPERI[i]. All outputs are registered.
- SVPERIOPBRK[i]<=SVPERIICE[i] | (SVMODOPBRK & PERIMSK[i]).
- MONSVMOD<=MONMD | SVMOD.
- STBRELEICE:
  - Set on STBRELE | STBRELESV.
  - Cleared on STBACK.
  - If set and clear occur in the same cycle, set wins.
- Reset values: SVSTOP=0, SVPERI=0, SVPERIOPBRK=0, STOPACK=0, MONSVMOD=0, STBRELEICE=0, cnt=0.
- Asynchronous reset mid-sequence returns to RUN and clears all outputs immediately.

## Timing
- All outputs change only on the CLK rising edge, one cycle after the sampled inputs.
- BRKREQ sampled high at edge t:
  - SVSTOP=1 and SVPERI[masked]=1 after edge t.
  - STOPACK=1 after edge t+1 at the earliest (PERIACK already high, or PERIMSK=0).
- BRKREQ sampled low in STOPPED at edge r:
  - SVPERI[masked] and STOPACK fall after edge r.
  - SVSTOP falls after edge r+1+RELCNT.
- RELCNT is sampled on entry to RELEASE. Changes to RELCNT during RELEASE are ignored.
- Pass-through latency is 1 cycle for SVPERI, SVPERIOPBRK and MONSVMOD.
- STBRELEICE rises 1 cycle after the request. It falls 1 cycle after STBACK when no new request arrives in that cycle.

## Test plan
- NPERI=4, PERIMSK=4'b0101, RELCNT=3:
  - Pulse SVMODI high at edge 0 -> SVSTOP=1 and SVPERI=0101 after edge 0.
  - Raise PERIACK=0101 at edge 5 -> STOPACK=1 after edge 5.
- From STOPPED, drop BRKREQ at edge 10 -> SVPERI=0000 and STOPACK=0 after edge 10; SVSTOP=0 after edge 14.
- Reassert SVSTOPICE during RELEASE, 2 cycles after the release started -> state STOP, SVPERI=0101 again, SVSTOP never falls.
- Drop BRKREQ while in STOP with PERIACK=0 -> remain in STOP. When PERIACK goes to 0101, STOPACK pulses high for 1 cycle, then the block releases.
- STBRELESV and STBACK high in the same cycle -> STBRELEICE=1. STBACK alone on the next cycle -> STBRELEICE=0.
- Assert RESB=0 mid-RELEASE -> all outputs 0 immediately. After RESB=1 with BRKREQ=0, the block stays in RUN.

Source files
------------

// File: rtl/svmod_ctrl.sv
// Purpose: merges OCD/ICE break requests and sequences CPU/peripheral-group stop and release.
// Latency: every output is registered, one cycle after the sampled inputs.
// Backpressure: the stop handshake waits on PERIACK of all masked groups and is never aborted.
module svmod_ctrl #(
  parameter int NPERI = 4,
  parameter int CW    = 4
) (
  input  logic             CLK,
  input  logic             RESB,
  input  logic             SVSTOPICE,
  input  logic             SVMODI,
  input  logic [NPERI-1:0] SVPERIICE,
  input  logic [NPERI-1:0] SVMODIPERI,
  input  logic             SVMODOPBRK,
  input  logic [NPERI-1:0] PERIMSK,
  input  logic [NPERI-1:0] PERIACK,
  input  logic [CW-1:0]    RELCNT,
  input  logic             MONMD,
  input  logic             SVMOD,
  input  logic             STBRELE,
  input  logic             STBRELESV,
  input  logic             STBACK,
  output logic             SVSTOP,
  output logic [NPERI-1:0] SVPERI,
  output logic [NPERI-1:0] SVPERIOPBRK,
  output logic             STOPACK,
  output logic             MONSVMOD,
  output logic             STBRELEICE
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STOP     = 2'd1,
    ST_STOPPED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             svstop_q, svstop_d;
  logic             stopack_q, stopack_d;
  logic [NPERI-1:0] svperi_q, svperi_d;
  logic [NPERI-1:0] opbrk_q, opbrk_d;
  logic             monsv_q, monsv_d;
  logic             stbrel_q, stbrel_d;

  logic             brkreq;
  logic             ackall;
  logic [NPERI-1:0] grpstop;

  // Break request merge and "every masked group has stopped" reduction.
  always_comb begin
    brkreq = SVSTOPICE | SVMODI;
    ackall = &(PERIACK | ~PERIMSK);
  end

  // Stop/release sequencer: next state, CPU stop, stop acknowledge and release delay counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    svstop_d  = svstop_q;
    stopack_d = stopack_q;
    unique case (state_q)
      ST_RUN: begin
        if (brkreq) begin
          state_d  = ST_STOP;
          svstop_d = 1'b1;
        end
      end
      ST_STOP: begin
        // Once started, a stop completes even if the request has already gone away.
        if (ackall) begin
          state_d   = ST_STOPPED;
          stopack_d = 1'b1;
        end
      end
      ST_STOPPED: begin
        if (!brkreq) begin
          state_d   = ST_RELEASE;
          stopack_d = 1'b0;
          cnt_d     = RELCNT;
        end
      end
      ST_RELEASE: begin
        // Peripherals are already running; the CPU is held until the delay expires.
        if (brkreq) begin
          state_d = ST_STOP;
        end else if (cnt_q == '0) begin
          state_d  = ST_RUN;
          svstop_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Group stop follows the state being entered so SVPERI moves together with SVSTOP/STOPACK.
  always_comb begin
    grpstop = '0;
    if ((state_d == ST_STOP) || (state_d == ST_STOPPED)) begin
      grpstop = PERIMSK;
    end
  end

  // Pass-through stop lines, monitor flag and held standby release (set beats clear).
  always_comb begin
    svperi_d = grpstop | SVPERIICE | SVMODIPERI;
    opbrk_d  = SVPERIICE | ({NPERI{SVMODOPBRK}} & PERIMSK);
    monsv_d  = MONMD | SVMOD;
    stbrel_d = stbrel_q;
    if (STBRELE || STBRELESV) begin
      stbrel_d = 1'b1;
    end else if (STBACK) begin
      stbrel_d = 1'b0;
    end
  end

  // State and output registers; reset returns to RUN with all outputs low.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      svstop_q  <= 1'b0;
      stopack_q <= 1'b0;
      svperi_q  <= '0;
      opbrk_q   <= '0;
      monsv_q   <= 1'b0;
      stbrel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      svstop_q  <= svstop_d;
      stopack_q <= stopack_d;
      svperi_q  <= svperi_d;
      opbrk_q   <= opbrk_d;
      monsv_q   <= monsv_d;
      stbrel_q  <= stbrel_d;
    end
  end

  assign SVSTOP      = svstop_q;
  assign SVPERI      = svperi_q;
  assign SVPERIOPBRK = opbrk_q;
  assign STOPACK     = stopack_q;
  assign MONSVMOD    = monsv_q;
  assign STBRELEICE  = stbrel_q;

endmodule

// File: tb/tb_svmod_ctrl.sv
// Purpose: self-checking bench for svmod_ctrl with NPERI=4, PERIMSK=0101.
// Latency: expectations are queued at drive time and popped 1ns after the next rising edge.
// Backpressure: none; PERIACK is driven from the vector table.
module tb_svmod_ctrl;

  logic       CLK = 1'b0;
  logic       RESB;
  logic       SVSTOPICE, SVMODI, SVMODOPBRK, MONMD, SVMOD;
  logic       STBRELE, STBRELESV, STBACK;
  logic [3:0] SVPERIICE, SVMODIPERI, PERIMSK, PERIACK, RELCNT;
  logic       SVSTOP, STOPACK, MONSVMOD, STBRELEICE;
  logic [3:0] SVPERI, SVPERIOPBRK;

  always #5 CLK = ~CLK;

  svmod_ctrl #(.NPERI(4), .CW(4)) dut (
    .CLK(CLK), .RESB(RESB),
    .SVSTOPICE(SVSTOPICE), .SVMODI(SVMODI),
    .SVPERIICE(SVPERIICE), .SVMODIPERI(SVMODIPERI),
    .SVMODOPBRK(SVMODOPBRK), .PERIMSK(PERIMSK), .PERIACK(PERIACK),
    .RELCNT(RELCNT), .MONMD(MONMD), .SVMOD(SVMOD),
    .STBRELE(STBRELE), .STBRELESV(STBRELESV), .STBACK(STBACK),
    .SVSTOP(SVSTOP), .SVPERI(SVPERI), .SVPERIOPBRK(SVPERIOPBRK),
    .STOPACK(STOPACK), .MONSVMOD(MONSVMOD), .STBRELEICE(STBRELEICE)
  );

  typedef struct {
    logic       svstop;
    logic [3:0] svperi;
    logic [3:0] opbrk;
    logic       stopack;
    logic       monsv;
    logic       stbrel;
  } exp_t;

  typedef struct {
    logic [1:0] brk;   // {SVSTOPICE, SVMODI}
    logic [3:0] ack;
    logic [3:0] pice;
    logic [3:0] pmod;
    logic       opb;
    logic [1:0] mon;   // {MONMD, SVMOD}
    logic [2:0] stb;   // {STBRELE, STBRELESV, STBACK}
    logic [3:0] rc;
    exp_t       e;
  } vec_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb_q[$];
  vec_t tbl[$];

  function automatic vec_t v(input logic [1:0] brk, input logic [3:0] ack, input logic [3:0] pice,
                             input logic [3:0] pmod, input logic opb, input logic [1:0] mon,
                             input logic [2:0] stb, input logic [3:0] rc, input logic e_ss,
                             input logic [3:0] e_sp, input logic [3:0] e_ob, input logic e_sa,
                             input logic e_ms, input logic e_sr);
    vec_t r;
    r.brk = brk; r.ack = ack; r.pice = pice; r.pmod = pmod; r.opb = opb;
    r.mon = mon; r.stb = stb; r.rc = rc;
    r.e.svstop = e_ss; r.e.svperi = e_sp; r.e.opbrk = e_ob;
    r.e.stopack = e_sa; r.e.monsv = e_ms; r.e.stbrel = e_sr;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %b, expected %b", nm, idx, act, exp);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_svstop"},  0, {3'b0, SVSTOP},     4'b0);
    chk({nm, "_svperi"},  0, SVPERI,             4'b0);
    chk({nm, "_opbrk"},   0, SVPERIOPBRK,        4'b0);
    chk({nm, "_stopack"}, 0, {3'b0, STOPACK},    4'b0);
    chk({nm, "_monsv"},   0, {3'b0, MONSVMOD},   4'b0);
    chk({nm, "_stbrel"},  0, {3'b0, STBRELEICE}, 4'b0);
  endtask

  task automatic drive(input vec_t t);
    {SVSTOPICE, SVMODI} = t.brk;
    PERIACK    = t.ack;
    SVPERIICE  = t.pice;
    SVMODIPERI = t.pmod;
    SVMODOPBRK = t.opb;
    {MONMD, SVMOD} = t.mon;
    {STBRELE, STBRELESV, STBACK} = t.stb;
    RELCNT     = t.rc;
  endtask

  // Drive one cycle of inputs (at the falling edge), queue its expectation, compare after the edge.
  task automatic apply(input vec_t t, input int idx);
    exp_t e;
    drive(t);
    sb_q.push_back(t.e);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    chk("svstop",  idx, {3'b0, SVSTOP},     {3'b0, e.svstop});
    chk("svperi",  idx, SVPERI,             e.svperi);
    chk("opbrk",   idx, SVPERIOPBRK,        e.opbrk);
    chk("stopack", idx, {3'b0, STOPACK},    {3'b0, e.stopack});
    chk("monsv",   idx, {3'b0, MONSVMOD},   {3'b0, e.monsv});
    chk("stbrel",  idx, {3'b0, STBRELEICE}, {3'b0, e.stbrel});
    @(negedge CLK);
  endtask

  initial begin
    //        brk    ack      pice     pmod     opb   mon    stb     rc    | ss    svperi   opbrk    sa    ms    sr
    // Break via SVMODI, held by SVSTOPICE; ack at edge 5; release at edge 10, CPU restarts after edge 14.
    tbl.push_back(v(2'b01, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0)); // 0
    tbl.push_back(v(2'b10, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0)); // 1
    tbl.push_back(v(2'b10, 4'b0000, 4'b1000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b1101, 4'b1000, 1'b0, 1'b0, 1'b0)); // 2
    tbl.push_back(v(2'b10, 4'b0000, 4'b0000, 4'b0010, 1'b1, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0111, 4'b0101, 1'b0, 1'b0, 1'b0)); // 3
    tbl.push_back(v(2'b10, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b10, 3'b000, 4'd3, 1'b1, 4'b0101, 4'b0000, 1'b0, 1'b1, 1'b0)); // 4
    tbl.push_back(v(2'b10, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0)); // 5
    tbl.push_back(v(2'b10, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b01, 3'b000, 4'd3, 1'b1, 4'b0101, 4'b0000, 1'b1, 1'b1, 1'b0)); // 6
    for (int i = 7; i <= 9; i++)
      tbl.push_back(v(2'b10, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0)); // 7-9
    tbl.push_back(v(2'b00, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)); // 10
    for (int i = 11; i <= 13; i++) // RELCNT changed during RELEASE must be ignored
      tbl.push_back(v(2'b00, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)); // 11-13
    tbl.push_back(v(2'b00, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)); // 14
    tbl.push_back(v(2'b00, 4'b0101, 4'b0010, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b0, 4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0)); // 15
    // Re-break two cycles into RELEASE, then a RELCNT=0 release.
    tbl.push_back(v(2'b10, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0)); // 16
    tbl.push_back(v(2'b10, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0)); // 17
    tbl.push_back(v(2'b00, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)); // 18
    tbl.push_back(v(2'b00, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)); // 19
    tbl.push_back(v(2'b10, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0)); // 20
    tbl.push_back(v(2'b10, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0)); // 21
    tbl.push_back(v(2'b00, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)); // 22
    tbl.push_back(v(2'b00, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)); // 23
    // Request dropped while still in STOP: stop completes, STOPACK pulses once, then release.
    tbl.push_back(v(2'b01, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0)); // 24
    tbl.push_back(v(2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0)); // 25
    tbl.push_back(v(2'b00, 4'b1010, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0)); // 26
    tbl.push_back(v(2'b00, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0)); // 27
    tbl.push_back(v(2'b00, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)); // 28
    for (int i = 29; i <= 31; i++)
      tbl.push_back(v(2'b00, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)); // 29-31
    tbl.push_back(v(2'b00, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)); // 32
    // Standby release hold: set beats clear, clear alone drops it, holds without either.
    tbl.push_back(v(2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b011, 4'd3, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1)); // 33
    tbl.push_back(v(2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b001, 4'd3, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)); // 34
    tbl.push_back(v(2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b100, 4'd3, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1)); // 35
    tbl.push_back(v(2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1)); // 36
    tbl.push_back(v(2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b001, 4'd3, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0)); // 37

    RESB    = 1'b0;
    PERIMSK = 4'b0101;
    drive(v(2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3,
            1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0));
    #12;
    chk_zero("reset");
    @(negedge CLK);
    RESB = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Enter RELEASE with several outputs high, then reset asynchronously mid-cycle.
    apply(v(2'b10, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0), 100);
    apply(v(2'b10, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0), 101);
    apply(v(2'b00, 4'b0101, 4'b0100, 4'b0000, 1'b0, 2'b10, 3'b100, 4'd3, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b1), 102);
    #2;
    RESB = 1'b0;
    #1;
    chk_zero("arst");
    drive(v(2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3,
            1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0));
    @(posedge CLK);
    @(negedge CLK);
    RESB = 1'b1;
    for (int i = 0; i < 3; i++)
      apply(v(2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0), 110 + i);
    apply(v(2'b01, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00, 3'b000, 4'd3, 1'b1, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0), 113);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
